dw_bc10_bsr_seg: RTL and testbench

- Parametrised single-clock boundary-scan register segment built from WIDTH BC_10-style observe/control cells.
- Gated by an IEEE 1687-style segment insertion bit (SIB), so the segment can be dropped from the scan path.
- Sits between the TAP/DR control logic and a bank of functional pins; scan chains through si/so.
- Differs from the single two-clock cell: one clock with capture/update enables, configurable width, per-cell mode, and dynamic segment bypass.

---
 rtl/dw_bsr_pkg.sv | 24 ++
 rtl/dw_bc10_cell_1clk.sv | 55 +++++
 rtl/dw_bc10_bsr_seg.sv | 99 +++++++++
 tb/tb_dw_bc10_bsr_seg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dw_bsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dw_bsr_pkg
// Description : Shared types and helpers for the BC_10 boundary-scan segment.
// Revision    : 1.0 - initial release
// ============================================================================
package dw_bsr_pkg;

    localparam int c_WIDTH_MIN = 1;
    localparam int c_WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_CAPTURE = 2'd1,
        OP_SHIFT   = 2'd2
    } cell_op_e;

    // Active scan length between si and so for a given SIB state.
    function automatic int chain_len(input logic open, input int width);
        return open ? (width + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dw_bc10_cell_1clk.sv
`default_nettype none
// ============================================================================
// Module      : dw_bc10_cell_1clk
// Description : Single-clock BC_10-style cell: capture/shift flop, update flop
//               and functional/test output mux.
// Revision    : 1.0 - initial release
// ============================================================================
module dw_bc10_cell_1clk
    import dw_bsr_pkg::*;
#(
    parameter logic UPD_RST_VAL = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  cell_op_e op,
    input  logic     upd_en,
    input  logic     si,
    input  logic     pin,
    input  logic     odata,
    input  logic     mode,
    output logic     so,
    output logic     data_out
);

    logic cap_q;
    logic cap_d;
    logic upd_q;

    always_comb begin
        cap_d = cap_q;
        case (op)
            OP_SHIFT:   cap_d = si;
            OP_CAPTURE: cap_d = pin;
            default:    cap_d = cap_q;
        endcase
    end

    // Update samples the pre-edge capture value, so a same-edge shift is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= 1'b0;
            upd_q <= UPD_RST_VAL;
        end else begin
            cap_q <= cap_d;
            if (upd_en) begin
                upd_q <= cap_q;
            end
        end
    end

    assign so       = cap_q;
    assign data_out = mode ? upd_q : odata;

endmodule
`default_nettype wire

// File: rtl/dw_bc10_bsr_seg.sv
`default_nettype none
// ============================================================================
// Module      : dw_bc10_bsr_seg
// Description : WIDTH-cell single-clock boundary-scan segment behind a SIB.
// Revision    : 1.0 - initial release
// ============================================================================
module dw_bc10_bsr_seg
    import dw_bsr_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter logic UPD_RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_en,
    input  logic             shift_dr,
    input  logic             update_en,
    input  logic [WIDTH-1:0] mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pin_input,
    input  logic [WIDTH-1:0] output_data,
    output logic [WIDTH-1:0] data_out,
    output logic             so,
    output logic             sib_open
);

    logic       sib_sh_q;
    logic       sib_sh_d;
    logic       sib_up_q;
    logic       sib_up_d;
    cell_op_e   w_op;
    logic       w_cell_upd;
    logic [WIDTH-1:0] w_cap_so;

    // A closed segment freezes every cell regardless of the enables.
    always_comb begin
        w_op = OP_HOLD;
        if (sib_up_q) begin
            if (shift_dr) begin
                w_op = OP_SHIFT;
            end else if (capture_en) begin
                w_op = OP_CAPTURE;
            end
        end
    end

    assign w_cell_upd = update_en & sib_up_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic w_cell_si;
            if (gi == 0) begin : g_head
                assign w_cell_si = si;
            end else begin : g_link
                assign w_cell_si = w_cap_so[gi-1];
            end

            dw_bc10_cell_1clk #(
                .UPD_RST_VAL (UPD_RST_VAL)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .op       (w_op),
                .upd_en   (w_cell_upd),
                .si       (w_cell_si),
                .pin      (pin_input[gi]),
                .odata    (output_data[gi]),
                .mode     (mode[gi]),
                .so       (w_cap_so[gi]),
                .data_out (data_out[gi])
            );
        end
    endgenerate

    always_comb begin
        sib_sh_d = sib_sh_q;
        if (shift_dr) begin
            sib_sh_d = sib_up_q ? w_cap_so[WIDTH-1] : si;
        end else if (capture_en) begin
            sib_sh_d = sib_up_q;
        end
        sib_up_d = update_en ? sib_sh_q : sib_up_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sib_sh_q <= 1'b0;
            sib_up_q <= 1'b0;
        end else begin
            sib_sh_q <= sib_sh_d;
            sib_up_q <= sib_up_d;
        end
    end

    assign so       = sib_sh_q;
    assign sib_open = sib_up_q;

endmodule
`default_nettype wire

// File: tb/tb_dw_bc10_bsr_seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dw_bc10_bsr_seg
// Description : Scoreboard bench for dw_bc10_bsr_seg with a chain-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dw_bc10_bsr_seg;
    import dw_bsr_pkg::*;

    localparam int c_W = 8;

    typedef struct {
        logic           so;
        logic           open;
        logic [c_W-1:0] dout;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           capture_en = 1'b0;
    logic           shift_dr = 1'b0;
    logic           update_en = 1'b0;
    logic [c_W-1:0] mode = '1;
    logic           si = 1'b0;
    logic [c_W-1:0] pin_input = '0;
    logic [c_W-1:0] output_data = 8'h5A;
    logic [c_W-1:0] data_out;
    logic           so;
    logic           sib_open;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];

    // Reference state: the whole open chain viewed as {sib_sh, cap}.
    logic [c_W-1:0] m_cap;
    logic [c_W-1:0] m_upd;
    logic           m_sh;
    logic           m_up;

    dw_bc10_bsr_seg #(.WIDTH(c_W), .UPD_RST_VAL(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_en  (capture_en),
        .shift_dr    (shift_dr),
        .update_en   (update_en),
        .mode        (mode),
        .si          (si),
        .pin_input   (pin_input),
        .output_data (output_data),
        .data_out    (data_out),
        .so          (so),
        .sib_open    (sib_open)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cap = '0;
        m_upd = '0;
        m_sh  = 1'b0;
        m_up  = 1'b0;
    endtask

    task automatic model_step();
        logic [c_W-1:0] cap_pre;
        logic           sh_pre;
        logic           up_pre;
        cap_pre = m_cap;
        sh_pre  = m_sh;
        up_pre  = m_up;
        if (up_pre) begin
            if (shift_dr) begin
                {m_sh, m_cap} = {cap_pre, si};
            end else if (capture_en) begin
                m_cap = pin_input;
                m_sh  = up_pre;
            end
            if (update_en) m_upd = cap_pre;
        end else begin
            if (shift_dr) m_sh = si;
            else if (capture_en) m_sh = up_pre;
        end
        if (update_en) m_up = sh_pre;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.so   = m_sh;
        e.open = m_up;
        e.dout = (mode & m_upd) | (~mode & output_data);
        return e;
    endfunction

    // One cycle: apply inputs, predict the outputs seen before the next edge,
    // then advance the model across that edge.
    task automatic drive(input logic c, input logic s, input logic u, input logic d);
        capture_en = c;
        shift_dr   = s;
        update_en  = u;
        si         = d;
        q.push_back(model_out());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic shift_word(input logic sh_bit, input logic [c_W-1:0] w);
        drive(1'b0, 1'b1, 1'b0, sh_bit);
        for (int i = c_W - 1; i >= 0; i--) drive(1'b0, 1'b1, 1'b0, w[i]);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("so", {7'd0, so}, {7'd0, e.so});
            check("sib_open", {7'd0, sib_open}, {7'd0, e.open});
            check("data_out", data_out, e.dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        check("rst_dout_mode_ff", data_out, 8'h00);
        check("rst_so", {7'd0, so}, 8'h00);
        check("rst_sib_open", {7'd0, sib_open}, 8'h00);
        mode = 8'h00;
        #1;
        check("rst_dout_mode_00", data_out, 8'h5A);
        mode = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Open the SIB, then capture and unload a pin pattern.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("chain_len_open", chain_len(sib_open, c_W), c_W + 1);
        pin_input = 8'hA5;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_W + 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Preload and update, then exercise the output mux.
        shift_word(1'b1, 8'h3C);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mode = 8'h0F;
        output_data = 8'hF0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mode = 8'hFF;

        // Shift and update on the same edge.
        shift_word(1'b1, 8'h81);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < c_W + 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a shift.
        shift_word(1'b1, 8'h3C);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        shift_dr = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_dout", data_out, 8'h00);
        check("midrst_so", {7'd0, so}, 8'h00);
        check("midrst_sib_open", {7'd0, sib_open}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic in both open and closed topologies.
        for (int n = 0; n < 600; n++) begin
            mode        = c_W'($urandom);
            output_data = c_W'($urandom);
            pin_input   = c_W'($urandom);
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom));
        end

        @(negedge clk);
        #1;
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
